// File: rtl/stb_pkg.sv
// Shared types and default geometry for the store buffer.
// Optional forwarding is enabled by defining STB_FWD_EN.
package stb_pkg;

  localparam int STB_DEF_DEPTH  = 8;
  localparam int STB_DEF_ADDR_W = 32;
  localparam int STB_DEF_DATA_W = 32;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_REQ  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [STB_DEF_ADDR_W-1:0]   addr;
    logic [STB_DEF_DATA_W-1:0]   wdata;
    logic [STB_DEF_DATA_W/8-1:0] sel_byte;
  } stb_entry_t;

endpackage

// File: rtl/stb_fwd_match.sv
// Store-to-load forwarding lookup: word-aligned compare against every valid
// entry, youngest match wins. Only instantiated when STB_FWD_EN is defined.
module stb_fwd_match #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0]   i_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]   i_data,
  input  logic [DEPTH-1:0][DATA_W/8-1:0] i_sel,
  input  logic [$clog2(DEPTH)-1:0]       i_rd_ptr,
  input  logic [$clog2(DEPTH):0]         i_count,
  input  logic                           i_ld_req,
  input  logic [ADDR_W-1:0]              i_ld_addr,
  output logic                           o_hit,
  output logic                           o_partial,
  output logic [DATA_W-1:0]              o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((DATA_W/8) - 1);

  logic                  w_found;
  logic [DATA_W/8-1:0]   w_sel;
  logic [DATA_W-1:0]     w_data;

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = i_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < i_count) && (((i_addr[idx] ^ i_ld_addr) & ALIGN_MASK) == '0)) begin
        w_found = 1'b1;
        w_sel   = i_sel[idx];
        w_data  = i_data[idx];
      end
    end
  end

  assign o_hit     = i_ld_req & w_found & (w_sel == '1);
  assign o_partial = i_ld_req & w_found & (w_sel != '0) & (w_sel != '1);
  assign o_data    = o_hit ? w_data : '0;

endmodule

// File: rtl/stb_param_ctrl.sv
// Store buffer: circular FIFO of pending stores drained to the data cache.
// Define STB_FWD_EN to add store-to-load forwarding ports and logic.
module stb_param_ctrl
  import stb_pkg::*;
#(
  parameter int DEPTH  = STB_DEF_DEPTH,
  parameter int ADDR_W = STB_DEF_ADDR_W,
  parameter int DATA_W = STB_DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lsummu2stb_req,
  input  logic                     lsummu2stb_w_en,
  input  logic                     dmem_sel_i,
  input  logic [ADDR_W-1:0]        lsummu2stb_addr,
  input  logic [DATA_W-1:0]        lsummu2stb_wdata,
  input  logic [DATA_W/8-1:0]      lsummu2stb_sel_byte,
  output logic                     stb2lsummu_ack,
  output logic                     stb2lsummu_stall,
  output logic                     stb2dcache_req,
  output logic [ADDR_W-1:0]        stb2dcache_addr,
  output logic [DATA_W-1:0]        stb2dcache_wdata,
  output logic [DATA_W/8-1:0]      stb2dcache_sel_byte,
  input  logic                     dcache2stb_ack,
`ifdef STB_FWD_EN
  input  logic                     lsummu2stb_ld_req,
  input  logic [ADDR_W-1:0]        lsummu2stb_ld_addr,
  output logic                     stb2lsummu_fwd_hit,
  output logic                     stb2lsummu_fwd_partial,
  output logic [DATA_W-1:0]        stb2lsummu_fwd_data,
`endif
  output logic                     stb_full,
  output logic                     stb_empty,
  output logic [$clog2(DEPTH):0]   stb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0]   r_addr;
  logic [DEPTH-1:0][DATA_W-1:0]   r_data;
  logic [DEPTH-1:0][DATA_W/8-1:0] r_sel;
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;
  drain_state_t                   r_state;
  logic                           r_dreq;
  logic                           r_ack;

  logic                           w_store_vld;
  logic                           w_push;
  logic                           w_pop;
  logic [CNT_W-1:0]               w_cnt_nxt;

  assign stb_count = r_count;
  assign stb_full  = (r_count == CNT_W'(DEPTH));
  assign stb_empty = (r_count == '0);

  assign w_store_vld      = lsummu2stb_req & lsummu2stb_w_en & dmem_sel_i;
  assign stb2lsummu_stall = w_store_vld & stb_full;
  // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
  assign w_push           = w_store_vld & ~stb_full;
  assign w_pop            = (r_state == D_REQ) & dcache2stb_ack;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_state  <= D_IDLE;
      r_dreq   <= 1'b0;
    end else begin
      r_ack   <= w_push;
      r_count <= w_cnt_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case (r_state)
        D_IDLE: begin
          if (!stb_empty) begin
            r_state <= D_REQ;
            r_dreq  <= 1'b1;
          end
        end
        D_REQ: begin
          if (w_pop && (w_cnt_nxt == '0)) begin
            r_state <= D_IDLE;
            r_dreq  <= 1'b0;
          end
        end
        default: begin
          r_state <= D_IDLE;
          r_dreq  <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= lsummu2stb_addr;
      r_data[r_wr_ptr] <= lsummu2stb_wdata;
      r_sel[r_wr_ptr]  <= lsummu2stb_sel_byte;
    end
  end

  assign stb2lsummu_ack      = r_ack;
  assign stb2dcache_req      = r_dreq;
  assign stb2dcache_addr     = r_dreq ? r_addr[r_rd_ptr] : '0;
  assign stb2dcache_wdata    = r_dreq ? r_data[r_rd_ptr] : '0;
  assign stb2dcache_sel_byte = r_dreq ? r_sel[r_rd_ptr]  : '0;

`ifdef STB_FWD_EN
  stb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_match (
    .i_addr    (r_addr),
    .i_data    (r_data),
    .i_sel     (r_sel),
    .i_rd_ptr  (r_rd_ptr),
    .i_count   (r_count),
    .i_ld_req  (lsummu2stb_ld_req),
    .i_ld_addr (lsummu2stb_ld_addr),
    .o_hit     (stb2lsummu_fwd_hit),
    .o_partial (stb2lsummu_fwd_partial),
    .o_data    (stb2lsummu_fwd_data)
  );
`endif

endmodule

// File: tb/tb_stb_param_ctrl.sv
// Randomized and directed bench for stb_param_ctrl against a queue-based model.
// Forwarding checks are active when STB_FWD_EN is defined.
module tb_stb_param_ctrl;
  import stb_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsummu2stb_req = 1'b0, lsummu2stb_w_en = 1'b0, dmem_sel_i = 1'b0;
  logic [31:0] lsummu2stb_addr = '0, lsummu2stb_wdata = '0;
  logic [3:0]  lsummu2stb_sel_byte = '0;
  logic        stb2lsummu_ack, stb2lsummu_stall, stb2dcache_req;
  logic [31:0] stb2dcache_addr, stb2dcache_wdata;
  logic [3:0]  stb2dcache_sel_byte;
  logic        dcache2stb_ack = 1'b0;
  logic        stb_full, stb_empty;
  logic [3:0]  stb_count;
`ifdef STB_FWD_EN
  logic        lsummu2stb_ld_req = 1'b0;
  logic [31:0] lsummu2stb_ld_addr = '0;
  logic        stb2lsummu_fwd_hit, stb2lsummu_fwd_partial;
  logic [31:0] stb2lsummu_fwd_data;
`endif

  always #5 clk = ~clk;

  stb_param_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsummu2stb_req      (lsummu2stb_req),
    .lsummu2stb_w_en     (lsummu2stb_w_en),
    .dmem_sel_i          (dmem_sel_i),
    .lsummu2stb_addr     (lsummu2stb_addr),
    .lsummu2stb_wdata    (lsummu2stb_wdata),
    .lsummu2stb_sel_byte (lsummu2stb_sel_byte),
    .stb2lsummu_ack      (stb2lsummu_ack),
    .stb2lsummu_stall    (stb2lsummu_stall),
    .stb2dcache_req      (stb2dcache_req),
    .stb2dcache_addr     (stb2dcache_addr),
    .stb2dcache_wdata    (stb2dcache_wdata),
    .stb2dcache_sel_byte (stb2dcache_sel_byte),
    .dcache2stb_ack      (dcache2stb_ack),
`ifdef STB_FWD_EN
    .lsummu2stb_ld_req      (lsummu2stb_ld_req),
    .lsummu2stb_ld_addr     (lsummu2stb_ld_addr),
    .stb2lsummu_fwd_hit     (stb2lsummu_fwd_hit),
    .stb2lsummu_fwd_partial (stb2lsummu_fwd_partial),
    .stb2lsummu_fwd_data    (stb2lsummu_fwd_data),
`endif
    .stb_full            (stb_full),
    .stb_empty           (stb_empty),
    .stb_count           (stb_count)
  );

  // Reference model: program-order queue of accepted stores.
  stb_entry_t q[$];
  bit         m_req;
  bit         m_ack;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_regs();
    check_eq("ack",   stb2lsummu_ack, m_ack);
    check_eq("count", stb_count, q.size());
    check_eq("full",  stb_full,  q.size() == DEPTH);
    check_eq("empty", stb_empty, q.size() == 0);
    check_eq("dreq",  stb2dcache_req, m_req);
    if (m_req && q.size() != 0) begin
      check_eq("head_addr",  stb2dcache_addr,     q[0].addr);
      check_eq("head_wdata", stb2dcache_wdata,    q[0].wdata);
      check_eq("head_sel",   stb2dcache_sel_byte, q[0].sel_byte);
    end
  endtask

`ifdef STB_FWD_EN
  task automatic check_fwd(input logic [31:0] la);
    bit         found = 0;
    stb_entry_t e;
    bit         exp_hit, exp_part;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!found && (((q[i].addr ^ la) & ~32'h3) == 0)) begin
        found = 1;
        e = q[i];
      end
    end
    exp_hit  = found && (e.sel_byte == 4'hF);
    exp_part = found && (e.sel_byte != 4'h0) && (e.sel_byte != 4'hF);
    check_eq("fwd_hit",     stb2lsummu_fwd_hit, exp_hit);
    check_eq("fwd_partial", stb2lsummu_fwd_partial, exp_part);
    if (exp_hit) check_eq("fwd_data", stb2lsummu_fwd_data, e.wdata);
  endtask
`endif

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance the model at the rising edge, check registered outputs at the next falling edge.
  task automatic step(input logic [2:0] qual, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit dack, input logic [31:0] la);
    bit vld, push, pop, was_req;
    int prev;
    stb_entry_t e;
    {lsummu2stb_req, lsummu2stb_w_en, dmem_sel_i} = qual;
    lsummu2stb_addr = a;
    lsummu2stb_wdata = d;
    lsummu2stb_sel_byte = m;
    dcache2stb_ack = dack;
`ifdef STB_FWD_EN
    lsummu2stb_ld_req = 1'b1;
    lsummu2stb_ld_addr = la;
`endif
    #1;
    vld = &qual;
    check_eq("stall", stb2lsummu_stall, vld && (q.size() == DEPTH));
`ifdef STB_FWD_EN
    check_fwd(la);
`endif
    push = vld && (q.size() < DEPTH);
    pop  = m_req && dack;
    @(posedge clk);
    prev = q.size();
    was_req = m_req;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.addr = a;
      e.wdata = d;
      e.sel_byte = m;
      q.push_back(e);
    end
    m_ack = push;
    m_req = was_req ? (q.size() != 0) : (prev != 0);
    @(negedge clk);
    check_regs();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit dack);
    step(3'b111, a, d, m, dack, a);
  endtask

  task automatic idle(input bit dack, input logic [31:0] la);
    step(3'b000, 32'h0, 32'h0, 4'h0, dack, la);
  endtask

  initial begin
    #1;
    check_eq("rst_empty", stb_empty, 1'b1);
    check_eq("rst_full",  stb_full, 1'b0);
    check_eq("rst_count", stb_count, 4'd0);
    check_eq("rst_ack",   stb2lsummu_ack, 1'b0);
    check_eq("rst_dreq",  stb2dcache_req, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single store, then drain.
    store(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    check_eq("single_ack", stb2lsummu_ack, 1'b1);
    check_eq("single_cnt", stb_count, 4'd1);
    idle(1'b0, 32'h100);
    check_eq("single_req",  stb2dcache_req, 1'b1);
    check_eq("single_addr", stb2dcache_addr, 32'h100);
    idle(1'b1, 32'h100);
    check_eq("single_empty", stb_empty, 1'b1);
    idle(1'b0, 32'h0);

    // Nine stores into a full buffer, one pop, then the ninth is taken.
    for (int i = 0; i < 9; i++) store(32'h200 + 32'(i * 4), $urandom, 4'hF, 1'b0);
    check_eq("fill_full", stb_full, 1'b1);
    store(32'h300, 32'hA5A5A5A5, 4'hF, 1'b1);
    store(32'h300, 32'hA5A5A5A5, 4'hF, 1'b0);
    check_eq("ninth_ack", stb2lsummu_ack, 1'b1);

    // Continuous drain across pointer wrap.
    for (int i = 0; i < 9; i++) idle(1'b1, 32'h200);
    check_eq("drain_empty", stb_empty, 1'b1);

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) store(32'h400 + 32'(i * 4), $urandom, 4'hF, 1'b0);
    idle(1'b0, 32'h0);
    store(32'h40C, 32'h0BADCAFE, 4'hF, 1'b1);
    check_eq("pushpop_cnt", stb_count, 4'd3);
    for (int i = 0; i < 5; i++) idle(1'b1, 32'h0);

`ifdef STB_FWD_EN
    store(32'h40, 32'h11111111, 4'hF, 1'b0);
    store(32'h40, 32'h22222222, 4'hF, 1'b0);
    idle(1'b0, 32'h40);
    check_eq("fwd_y_hit",  stb2lsummu_fwd_hit, 1'b1);
    check_eq("fwd_y_data", stb2lsummu_fwd_data, 32'h22222222);
    store(32'h80, 32'h33333333, 4'h3, 1'b0);
    idle(1'b0, 32'h80);
    check_eq("fwd_p_part", stb2lsummu_fwd_partial, 1'b1);
    check_eq("fwd_p_hit",  stb2lsummu_fwd_hit, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1, 32'h40);
`endif

    // Asynchronous reset in the middle of a drain with five entries.
    for (int i = 0; i < 5; i++) store(32'h500 + 32'(i * 4), $urandom, 4'hF, 1'b0);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dreq",  stb2dcache_req, 1'b0);
    check_eq("arst_count", stb_count, 4'd0);
    check_eq("arst_empty", stb_empty, 1'b1);
    check_eq("arst_ack",   stb2lsummu_ack, 1'b0);
    q.delete();
    m_req = 0;
    m_ack = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with aliasing addresses and mixed masks.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  qual;
      logic [3:0]  msk;
      logic [31:0] a;
      logic [31:0] la;
      bit          dack;
      qual = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom);
      case ($urandom_range(0, 3))
        0:       msk = 4'h3;
        1:       msk = 4'($urandom);
        default: msk = 4'hF;
      endcase
      a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) | 32'h1000;
      la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) | 32'h1000;
      dack = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(qual, a, $urandom, msk, dack, la);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
